ceespu_decode: RTL

Decode/operand-fetch stage of the ceespu pipeline, sitting between instruction fetch and the execute stage. It holds the 32x32 register file and cracks each 32-bit instruction into the registered control/operand bundle that the execute stage consumes. It writes back execute results and interlocks on read-after-write hazards, multi-cycle ALU busy and taken-branch flushes.

---
 rtl/ceespu_decode.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/ceespu_decode.sv
// ceespu decode/operand-fetch stage: 32x32 register file, instruction cracking and hazard interlock.
// Define CEESPU_REGFILE_BYPASS_EN to forward same-cycle writeback data to register reads.
module ceespu_decode (
  input  logic        I_clk,
  input  logic        I_rst,
  input  logic [31:0] I_instr,
  input  logic [13:0] I_PC,
  input  logic        I_valid,
  input  logic        I_busy,
  input  logic        I_taken,
  input  logic [4:0]  I_wbSel,
  input  logic        I_wbWe,
  input  logic [31:0] I_wbData,
  output logic [4:0]  O_selD,
  output logic [3:0]  O_aluop,
  output logic        O_we,
  output logic        O_branch,
  output logic [1:0]  O_selWb,
  output logic [2:0]  O_branchop,
  output logic [31:0] O_dataA,
  output logic [31:0] O_dataB,
  output logic [1:0]  O_selCin,
  output logic [3:0]  O_selMem,
  output logic [13:0] O_PC,
  output logic [13:0] O_target,
  output logic [31:0] O_memAddr,
  output logic        O_memWe,
  output logic [31:0] O_memData,
  output logic        O_stall
);

  typedef enum logic [2:0] {
    CLS_BUBBLE, CLS_ALU_RR, CLS_ALU_RI, CLS_LOAD, CLS_BRANCH, CLS_STORE, CLS_JAL
  } cls_t;

  typedef struct packed {
    logic [4:0]  sel_d;
    logic [3:0]  aluop;
    logic        we;
    logic        branch;
    logic [1:0]  sel_wb;
    logic [2:0]  branchop;
    logic [31:0] data_a;
    logic [31:0] data_b;
    logic [1:0]  sel_cin;
    logic [3:0]  sel_mem;
    logic [13:0] pc;
    logic [13:0] target;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [31:0] mem_data;
  } bundle_t;

  logic [31:0] regs_q [32];
  logic [31:0] regs_d [32];
  bundle_t     out_q, out_d, dec;
  cls_t        cls;

  logic [5:0]  op;
  logic [4:0]  rd, ra, rb;
  logic [15:0] imm16;
  logic [31:0] simm;
  logic [31:0] val_ra, val_rb, val_rd;
  logic        use_ra, use_rb, use_rd;
  logic        ex_hit, wb_hit, hazard;

  assign op    = I_instr[31:26];
  assign rd    = I_instr[25:21];
  assign ra    = I_instr[20:16];
  assign rb    = I_instr[15:11];
  assign imm16 = I_instr[15:0];
  assign simm  = {{16{imm16[15]}}, imm16};

  always_comb begin
    regs_d = regs_q;
    if (I_wbWe && I_wbSel != 5'd0) regs_d[I_wbSel] = I_wbData;
  end

  always_ff @(posedge I_clk or negedge I_rst) begin
    if (!I_rst) regs_q <= '{default: '0};
    else        regs_q <= regs_d;
  end

  // R0 is never written, so it reads as zero without a special case.
`ifdef CEESPU_REGFILE_BYPASS_EN
  assign val_ra = (I_wbWe && I_wbSel == ra && ra != 5'd0) ? I_wbData : regs_q[ra];
  assign val_rb = (I_wbWe && I_wbSel == rb && rb != 5'd0) ? I_wbData : regs_q[rb];
  assign val_rd = (I_wbWe && I_wbSel == rd && rd != 5'd0) ? I_wbData : regs_q[rd];
`else
  assign val_ra = regs_q[ra];
  assign val_rb = regs_q[rb];
  assign val_rd = regs_q[rd];
`endif

  always_comb begin
    casez (op)
      6'b00????: cls = CLS_ALU_RR;
      6'b01????: cls = CLS_ALU_RI;
      6'b10????: cls = CLS_LOAD;
      6'b110???: cls = CLS_BRANCH;
      6'b1110??: cls = CLS_STORE;
      6'b111100: cls = CLS_JAL;
      default:   cls = CLS_BUBBLE;
    endcase
  end

  assign use_ra = (cls == CLS_ALU_RR) || (cls == CLS_ALU_RI) || (cls == CLS_LOAD) ||
                  (cls == CLS_BRANCH) || (cls == CLS_STORE);
  assign use_rb = (cls == CLS_ALU_RR) || (cls == CLS_BRANCH);
  assign use_rd = (cls == CLS_STORE);

  assign ex_hit = out_q.we && (out_q.sel_d != 5'd0) &&
                  ((use_ra && ra == out_q.sel_d) || (use_rb && rb == out_q.sel_d) ||
                   (use_rd && rd == out_q.sel_d));
`ifdef CEESPU_REGFILE_BYPASS_EN
  assign wb_hit = 1'b0;
`else
  // Without forwarding, the value being written this cycle is not yet readable.
  assign wb_hit = I_wbWe && (I_wbSel != 5'd0) &&
                  ((use_ra && ra == I_wbSel) || (use_rb && rb == I_wbSel) ||
                   (use_rd && rd == I_wbSel));
`endif
  assign hazard  = I_valid && (ex_hit || wb_hit);
  assign O_stall = !I_taken && (I_busy || hazard);

  always_comb begin
    dec = '0;
    if (cls != CLS_BUBBLE) begin
      dec.pc     = I_PC + 14'd1;
      dec.target = I_PC + imm16[13:0];
    end
    case (cls)
      CLS_ALU_RR, CLS_ALU_RI: begin
        dec.aluop   = op[3:0];
        dec.data_a  = val_ra;
        dec.data_b  = (cls == CLS_ALU_RR) ? val_rb : simm;
        dec.sel_cin = (cls == CLS_ALU_RR) ? I_instr[1:0] : 2'd0;
        dec.we      = 1'b1;
        dec.sel_d   = rd;
      end
      CLS_LOAD: begin
        dec.sel_mem  = op[3:0];
        dec.mem_addr = val_ra + simm;
        dec.we       = 1'b1;
        dec.sel_wb   = 2'd1;
        dec.sel_d    = rd;
      end
      CLS_BRANCH: begin
        dec.branch   = 1'b1;
        dec.branchop = op[2:0];
        dec.data_a   = val_ra;
        dec.data_b   = val_rb;
      end
      CLS_STORE: begin
        dec.mem_we   = 1'b1;
        dec.mem_addr = val_ra + simm;
        dec.mem_data = val_rd;
        dec.sel_mem  = {2'b00, op[1:0]};
      end
      CLS_JAL: begin
        dec.branch   = 1'b1;
        dec.branchop = 3'b111;
        dec.we       = 1'b1;
        dec.sel_wb   = 2'd2;
        dec.sel_d    = rd;
      end
      default: ;
    endcase
  end

  always_comb begin
    out_d = out_q;
    if (I_taken)                  out_d = '0;
    else if (I_busy)              out_d = out_q;
    else if (hazard || !I_valid)  out_d = '0;
    else                          out_d = dec;
  end

  always_ff @(posedge I_clk or negedge I_rst) begin
    if (!I_rst) out_q <= '0;
    else        out_q <= out_d;
  end

  assign O_selD     = out_q.sel_d;
  assign O_aluop    = out_q.aluop;
  assign O_we       = out_q.we;
  assign O_branch   = out_q.branch;
  assign O_selWb    = out_q.sel_wb;
  assign O_branchop = out_q.branchop;
  assign O_dataA    = out_q.data_a;
  assign O_dataB    = out_q.data_b;
  assign O_selCin   = out_q.sel_cin;
  assign O_selMem   = out_q.sel_mem;
  assign O_PC       = out_q.pc;
  assign O_target   = out_q.target;
  assign O_memAddr  = out_q.mem_addr;
  assign O_memWe    = out_q.mem_we;
  assign O_memData  = out_q.mem_data;

endmodule
